hazard_ctrl: RTL and testbench

- Parametrised hazard-control unit for the LC-3b 5-stage pipeline. It inserts bubbles for load-use hazards and for control-transfer shadows, and squashes ID when a branch resolves taken.
- Sits between the IF/ID and ID/EX pipeline registers. Drives the bubble mux and the ID squash/flush.
- Improves on the fixed-depth bubble logic:
  - configurable shadow depth;
  - multi-cycle load bubbles, with a separate depth for LDI;
  - a pipeline-freeze input;
  - valid qualification;
  - reset.

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use and control-transfer-shadow hazard control for the LC-3b 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating bubble/squash event counters.
module hazard_ctrl #(
    parameter int unsigned SHADOW_DEPTH = 5,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned LDI_BUBBLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_id_valid,
    input  logic [15:0] if_id_ir,
    input  logic        id_ex_valid,
    input  logic [15:0] id_ex_ir,
    input  logic        branch_enable,
    output logic        gen_bubble,
    output logic        squash_id,
    output logic        shadow_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] bubble_count,
    output logic [15:0] squash_count
`endif
);

    // state   | meaning
    // IDLE    | no control transfer in flight
    // SHADOW  | bubbling behind a control transfer, count >= 2
    // RESOLVE | last shadow cycle, squash ID if the branch was taken
    typedef enum logic [1:0] {IDLE, SHADOW, RESOLVE} state_t;

    localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB, OP_JMP = 4'hC;
    localparam logic [3:0] OP_SHF = 4'hD, OP_TRAP = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] shadow_cnt_q, shadow_cnt_d;
    logic [2:0] load_cnt_q, load_cnt_d;
    logic       br_latch_q;

    logic [3:0] if_op, ex_op;
    logic [2:0] load_dr;
    logic       sr1_en, sr2_en, st_en;
    logic       id_is_load, load_hazard, ctrl_instr;
    logic       unused_ex_bits;

    assign if_op          = if_id_ir[15:12];
    assign ex_op          = id_ex_ir[15:12];
    assign load_dr        = id_ex_ir[11:9];
    assign unused_ex_bits = ^id_ex_ir[8:0];

    always_comb begin
        sr1_en = 1'b0;
        sr2_en = 1'b0;
        st_en  = 1'b0;
        case (if_op)
            OP_ADD, OP_AND: begin
                sr1_en = 1'b1;
                sr2_en = ~if_id_ir[5];
            end
            OP_NOT, OP_SHF, OP_LDB, OP_LDR, OP_JMP: sr1_en = 1'b1;
            OP_STB, OP_STR, OP_STI: begin
                sr1_en = 1'b1;
                st_en  = 1'b1;
            end
            OP_JSR:  sr1_en = ~if_id_ir[11];
            default: ;
        endcase
    end

    assign id_is_load  = id_ex_valid && (ex_op == OP_LDB || ex_op == OP_LDR || ex_op == OP_LDI);
    assign load_hazard = if_id_valid && id_is_load &&
                         ((sr1_en && if_id_ir[8:6]  == load_dr) ||
                          (sr2_en && if_id_ir[2:0]  == load_dr) ||
                          (st_en  && if_id_ir[11:9] == load_dr));
    assign ctrl_instr  = if_id_valid && (if_id_ir != 16'h0000) &&
                         (if_op == OP_BR || if_op == OP_JMP || if_op == OP_JSR || if_op == OP_TRAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_cnt_q <= 4'd0;
            load_cnt_q   <= 3'd0;
            br_latch_q   <= 1'b0;
        end else if (!stall) begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            load_cnt_q   <= load_cnt_d;
            br_latch_q   <= branch_enable;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        load_cnt_d   = load_cnt_q;
        if (ctrl_instr) begin
            state_d      = SHADOW;
            shadow_cnt_d = 4'(SHADOW_DEPTH);
        end else begin
            case (state_q)
                SHADOW: begin
                    if (shadow_cnt_q != 4'd0) shadow_cnt_d = shadow_cnt_q - 4'd1;
                    if (shadow_cnt_q <= 4'd2) state_d = RESOLVE;
                end
                RESOLVE: begin
                    shadow_cnt_d = 4'd0;
                    state_d      = IDLE;
                end
                default: ;
            endcase
        end
        // A hazard seen while bubbles are still pending does not extend the run.
        if (load_cnt_q != 3'd0)
            load_cnt_d = load_cnt_q - 3'd1;
        else if (load_hazard)
            load_cnt_d = (ex_op == OP_LDI) ? 3'(LDI_BUBBLES - 1) : 3'(LOAD_BUBBLES - 1);
    end

    always_comb begin
        gen_bubble  = 1'b0;
        squash_id   = 1'b0;
        shadow_busy = !reset && (shadow_cnt_q != 4'd0);
        if (!reset && !stall) begin
            gen_bubble = (load_cnt_q != 3'd0) || load_hazard || (state_q == SHADOW);
            squash_id  = (state_q == RESOLVE) && br_latch_q;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= 16'h0000;
            squash_count <= 16'h0000;
        end else begin
            if (gen_bubble && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'h0001;
            if (squash_id && squash_count != 16'hFFFF) squash_count <= squash_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus against a cycle model.
// Stats counters are checked when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

    localparam int SHADOW_DEPTH = 5;
    localparam int LOAD_BUBBLES = 1;
    localparam int LDI_BUBBLES  = 2;

    logic        clk = 1'b0;
    logic        reset, stall, if_id_valid, id_ex_valid, branch_enable;
    logic [15:0] if_id_ir, id_ex_ir;
    logic        gen_bubble, squash_id, shadow_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] bubble_count, squash_count;
`endif

    int errors = 0;
    int checks = 0;
    int m_shadow = 0;
    int m_load   = 0;
    bit m_latch  = 1'b0;
    int m_bubbles = 0;
    int m_squashes = 0;
    int gb_seen = 0;
    int sq_seen = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .SHADOW_DEPTH(SHADOW_DEPTH),
        .LOAD_BUBBLES(LOAD_BUBBLES),
        .LDI_BUBBLES (LDI_BUBBLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .if_id_valid  (if_id_valid),
        .if_id_ir     (if_id_ir),
        .id_ex_valid  (id_ex_valid),
        .id_ex_ir     (id_ex_ir),
        .branch_enable(branch_enable),
        .gen_bubble   (gen_bubble),
        .squash_id    (squash_id),
        .shadow_busy  (shadow_busy)
`ifdef HAZARD_STATS_EN
        ,
        .bubble_count (bubble_count),
        .squash_count (squash_count)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Registers an instruction reads, straight from the LC-3b operand rules.
    function automatic bit reads_reg(input logic [15:0] ir, input logic [2:0] r);
        int op;
        bit s1, s2, st;
        op = int'(ir[15:12]);
        s1 = (op inside {1, 5, 9, 13, 2, 6, 3, 7, 11, 12}) || (op == 4 && ir[11] == 1'b0);
        s2 = (op == 1 || op == 5) && ir[5] == 1'b0;
        st = op inside {3, 7, 11};
        return (s1 && ir[8:6] == r) || (s2 && ir[2:0] == r) || (st && ir[11:9] == r);
    endfunction

    function automatic bit model_hazard();
        int op;
        op = int'(id_ex_ir[15:12]);
        return if_id_valid && id_ex_valid && (op inside {2, 6, 10}) && reads_reg(if_id_ir, id_ex_ir[11:9]);
    endfunction

    function automatic bit model_ctrl();
        return if_id_valid && if_id_ir != 16'h0 && (int'(if_id_ir[15:12]) inside {0, 4, 12, 15});
    endfunction

    task automatic cycle();
        bit haz, ctl, eb, es, ebusy;
        int depth;
        haz   = model_hazard();
        ctl   = model_ctrl();
        eb    = !stall && (m_load > 0 || haz || m_shadow >= 2);
        es    = !stall && m_shadow == 1 && m_latch;
        ebusy = m_shadow != 0;
        @(negedge clk);
        chk("gen_bubble", gen_bubble, eb);
        chk("squash_id", squash_id, es);
        chk("shadow_busy", shadow_busy, ebusy);
`ifdef HAZARD_STATS_EN
        chk("bubble_count", bubble_count, 16'(m_bubbles));
        chk("squash_count", squash_count, 16'(m_squashes));
`endif
        if (gen_bubble === 1'b1) gb_seen++;
        if (squash_id === 1'b1) sq_seen++;
        @(posedge clk);
        if (!stall) begin
            if (ctl) m_shadow = SHADOW_DEPTH;
            else if (m_shadow > 0) m_shadow--;
            depth = (id_ex_ir[15:12] == 4'hA) ? LDI_BUBBLES : LOAD_BUBBLES;
            if (m_load > 0) m_load--;
            else if (haz) m_load = depth - 1;
            m_latch = branch_enable;
            if (eb && m_bubbles < 65535) m_bubbles++;
            if (es && m_squashes < 65535) m_squashes++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gen_bubble", gen_bubble, 1'b0);
        chk("rst_squash_id", squash_id, 1'b0);
        chk("rst_shadow_busy", shadow_busy, 1'b0);
        m_shadow = 0; m_load = 0; m_latch = 1'b0; m_bubbles = 0; m_squashes = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; if_id_valid = 1'b0; if_id_ir = 16'h0;
        id_ex_valid = 1'b0; id_ex_ir = 16'h0; branch_enable = 1'b0;
    endtask

    function automatic logic [15:0] rand_if_ir();
        logic [15:0] ir;
        ir = 16'($urandom);
        if ((int'(ir[15:12]) inside {0, 4, 12, 15}) && $urandom_range(0, 3) != 0) ir[15:12] = 4'h1;
        return ir;
    endfunction

    function automatic logic [15:0] rand_id_ir();
        logic [15:0] ir;
        ir = 16'($urandom);
        case ($urandom_range(0, 5))
            0: ir[15:12] = 4'h2;
            1: ir[15:12] = 4'h6;
            2: ir[15:12] = 4'hA;
            default: ;
        endcase
        return ir;
    endfunction

    initial begin
        idle_inputs();
        do_reset();

        // Reset in the middle of a shadow abandons it.
        if_id_valid = 1'b1; if_id_ir = 16'h0E02; branch_enable = 1'b1;
        cycle();
        if_id_ir = 16'h0000;
        cycle();
        do_reset();
        sq_seen = 0; gb_seen = 0;
        repeat (6) cycle();
        chk("rst_mid_shadow_squash", 16'(sq_seen), 16'd0);
        chk("rst_mid_shadow_bubbles", 16'(gb_seen), 16'd0);

        // LDR load-use: one bubble, then ID/EX carries the inserted NOP.
        idle_inputs();
        gb_seen = 0;
        id_ex_valid = 1'b1; id_ex_ir = 16'h6240; if_id_valid = 1'b1; if_id_ir = 16'h1443;
        cycle();
        id_ex_valid = 1'b0; id_ex_ir = 16'h0000;
        repeat (3) cycle();
        chk("ldr_bubbles", 16'(gb_seen), 16'd1);

        // LDI load-use: two bubbles.
        gb_seen = 0;
        id_ex_valid = 1'b1; id_ex_ir = 16'hA201;
        cycle();
        id_ex_valid = 1'b0; id_ex_ir = 16'h0000;
        repeat (3) cycle();
        chk("ldi_bubbles", 16'(gb_seen), 16'd2);

        // Same LDI hazard with IF/ID invalid: no bubble.
        gb_seen = 0;
        if_id_valid = 1'b0; id_ex_valid = 1'b1; id_ex_ir = 16'hA201;
        repeat (2) cycle();
        chk("ldi_invalid_bubbles", 16'(gb_seen), 16'd0);

        // Taken branch: four bubbles then a squash on the resolve cycle.
        idle_inputs();
        if_id_valid = 1'b1; if_id_ir = 16'h0E02; branch_enable = 1'b1;
        cycle();
        gb_seen = 0; sq_seen = 0;
        if_id_ir = 16'h0000;
        repeat (4) cycle();
        chk("taken_bubbles", 16'(gb_seen), 16'd4);
        chk("taken_no_early_squash", 16'(sq_seen), 16'd0);
        cycle();
        chk("taken_squash", 16'(sq_seen), 16'd1);
        repeat (2) cycle();

        // Not-taken branch: bubbles but no squash.
        if_id_ir = 16'h0E02; branch_enable = 1'b0;
        cycle();
        gb_seen = 0; sq_seen = 0;
        if_id_ir = 16'h0000;
        repeat (6) cycle();
        chk("nt_bubbles", 16'(gb_seen), 16'd4);
        chk("nt_squash", 16'(sq_seen), 16'd0);

        // Stall right after the branch loads the shadow.
        if_id_ir = 16'h0E02; branch_enable = 1'b1;
        cycle();
        gb_seen = 0; sq_seen = 0;
        if_id_ir = 16'h0000; stall = 1'b1;
        repeat (3) cycle();
        chk("stall_no_bubble", 16'(gb_seen), 16'd0);
        chk("stall_busy_held", 16'(shadow_busy), 16'd1);
        stall = 1'b0;
        repeat (6) cycle();
        chk("stall_bubbles", 16'(gb_seen), 16'd4);
        chk("stall_squash", 16'(sq_seen), 16'd1);

`ifdef HAZARD_STATS_EN
        // Taken branch followed by an LDR hazard: five bubbles, one squash.
        idle_inputs();
        do_reset();
        if_id_valid = 1'b1; if_id_ir = 16'h0E02; branch_enable = 1'b1;
        cycle();
        if_id_ir = 16'h0000;
        repeat (6) cycle();
        id_ex_valid = 1'b1; id_ex_ir = 16'h6240; if_id_ir = 16'h1443;
        cycle();
        idle_inputs();
        cycle();
        chk("stats_bubble_total", bubble_count, 16'd5);
        chk("stats_squash_total", squash_count, 16'd1);
`endif

        // Random traffic against the model.
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            stall         = ($urandom_range(0, 5) == 0);
            if_id_valid   = ($urandom_range(0, 7) != 0);
            if_id_ir      = rand_if_ir();
            id_ex_valid   = ($urandom_range(0, 7) != 0);
            id_ex_ir      = rand_id_ir();
            branch_enable = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
